// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - fetch-side instruction memory with a LATENCY-deep response pipeline
// Optional misalignment flagging (resp_err_out) under INSTR_MISALIGN_CHECK_EN.
module instr_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    output logic              req_ready_out,
    input  logic              hold_in,
    input  logic              flush_in,
    output logic              resp_valid_out,
    output logic [ADDR_W-1:0] resp_addr_out,
    output logic [DATA_W-1:0] resp_instr_out,
    output logic              busy_out,
`ifdef INSTR_MISALIGN_CHECK_EN
    output logic              resp_err_out,
`endif
    input  logic              wr_en_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] wr_data_in
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [DATA_W-1:0]  mem_q [DEPTH_WORDS];

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]  addr_q  [LATENCY];
    logic [ADDR_W-1:0]  addr_d  [LATENCY];
    logic [DATA_W-1:0]  instr_q [LATENCY];
    logic [DATA_W-1:0]  instr_d [LATENCY];
`ifdef INSTR_MISALIGN_CHECK_EN
    logic [LATENCY-1:0] err_q, err_d;
    logic               misaligned;
`endif

    logic               accept;
    logic               rd_in_range;
    logic               wr_in_range;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic [DATA_W-1:0]  rd_data;
    logic               unused_wr_lsb;

    assign req_ready_out = ~hold_in & ~rst;
    assign accept        = req_valid_in & req_ready_out;

    assign rd_idx      = req_addr_in[IDX_W+1:2];
    assign wr_idx      = wr_addr_in[IDX_W+1:2];
    assign rd_in_range = (req_addr_in >> (IDX_W + 2)) == '0;
    assign wr_in_range = (wr_addr_in >> (IDX_W + 2)) == '0;
    assign unused_wr_lsb = ^wr_addr_in[1:0];

    // Array is read combinationally at accept, so a same-edge write is not yet visible.
`ifdef INSTR_MISALIGN_CHECK_EN
    assign misaligned = |req_addr_in[1:0];
    assign rd_data    = (rd_in_range && !misaligned) ? mem_q[rd_idx] : '0;
`else
    assign rd_data    = rd_in_range ? mem_q[rd_idx] : '0;
`endif

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        instr_d = instr_q;
`ifdef INSTR_MISALIGN_CHECK_EN
        err_d   = err_q;
`endif
        if (!hold_in) begin
            valid_d[0] = accept;
            addr_d[0]  = req_addr_in;
            instr_d[0] = rd_data;
`ifdef INSTR_MISALIGN_CHECK_EN
            err_d[0]   = accept & misaligned;
`endif
            for (int i = 1; i < LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
                addr_d[i]  = addr_q[i-1];
                instr_d[i] = instr_q[i-1];
`ifdef INSTR_MISALIGN_CHECK_EN
                err_d[i]   = err_q[i-1];
`endif
            end
        end
        // Flush beats hold; only the branch-target request survives.
        if (flush_in) begin
            valid_d    = '0;
            valid_d[0] = accept;
`ifdef INSTR_MISALIGN_CHECK_EN
            err_d      = '0;
            err_d[0]   = accept & misaligned;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
`ifdef INSTR_MISALIGN_CHECK_EN
            err_q   <= '0;
`endif
            for (int i = 0; i < LATENCY; i++) begin
                addr_q[i]  <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
`ifdef INSTR_MISALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_in && wr_in_range) begin
            mem_q[wr_idx] <= wr_data_in;
        end
    end

    assign resp_valid_out = valid_q[LATENCY-1];
    assign resp_addr_out  = addr_q[LATENCY-1];
    assign resp_instr_out = instr_q[LATENCY-1];
    assign busy_out       = (|valid_q) | accept;
`ifdef INSTR_MISALIGN_CHECK_EN
    assign resp_err_out   = err_q[LATENCY-1];
`endif

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Instruction-memory responder that sits on the memory side of the fetch interface.
- The fetch stage presents a PC as a request. This block returns the addressed 32-bit instruction after a fixed pipelined latency.
- Supports hold (pipeline freeze) and flush (branch taken), so wrong-path fetches are discarded in flight.
- Includes a synchronous write port for program preload by the bench or boot logic.

Parameters:
- ADDR_W, 32, request/response address width.
- DATA_W, 32, instruction width.
- DEPTH_WORDS, 256, memory depth in words; power of two.
- LATENCY, 2, cycles from request accept to response valid; legal 1..4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid_in  input  1  fetch request present.
- req_addr_in  input  ADDR_W  byte address (PC) of the request.
- req_ready_out  output  1  request accepted this cycle when high together with req_valid_in.
- hold_in  input  1  freeze: the whole response pipeline stalls.
- flush_in  input  1  kill all in-flight requests (branch taken).
- resp_valid_out  output  1  response valid.
- resp_addr_out  output  ADDR_W  address of the returned instruction.
- resp_instr_out  output  DATA_W  returned instruction.
- busy_out  output  1  at least one request is in flight or being presented.
- wr_en_in  input  1  preload write enable.
- wr_addr_in  input  ADDR_W  preload byte address.
- wr_data_in  input  DATA_W  preload data.

Behaviour:
- Reset (asynchronous, rst=1):
  - All stage valid bits are cleared.
  - resp_valid_out=0, resp_addr_out=0, resp_instr_out=0, busy_out=0.
  - req_ready_out=0 while rst is high.
  - Memory array contents are not reset.
  - Reset asserted mid-operation discards every in-flight request; nothing is returned for them.
- Word index: req_addr_in[log2(DEPTH_WORDS)+1:2].
  - Addresses at or above DEPTH_WORDS*4 return instruction 0.
  - The address is still echoed on resp_addr_out.
- Accept rule: req_ready_out = ~hold_in & ~rst. A request is accepted when req_valid_in & req_ready_out.
- Pipeline:
  - LATENCY stages, each holding {valid, addr, instr}.
  - The memory array is read at accept; data enters stage 1.
  - Data shifts one stage per cycle when hold_in=0.
  - resp_* outputs are driven from the last stage, so a request accepted in cycle N appears valid in cycle N+LATENCY if there is no hold.
  - Throughput is one request per cycle.
- Hold: when hold_in=1, all stages and the resp_* outputs keep their values and no request is accepted. Responses are therefore repeated, not lost, across hold cycles.
- Flush: when flush_in=1 at a rising edge, every stage valid bit is cleared.
  - A request accepted in the same cycle as the flush is kept and loaded into stage 1 as valid, because it is the branch target.
  - Flush takes priority over hold for valid bits; data fields are don't-care.
  - The first cycle after a flush shows resp_valid_out=0 unless LATENCY=1 and a same-cycle request was accepted.
- Write port:
  - Synchronous write on a rising edge when wr_en_in=1.
  - Writes are independent of hold and flush.
  - Out-of-range write addresses are ignored.
  - A same-cycle write and accepted read of the same word returns the old data.
- busy_out = OR of all stage valid bits OR (req_valid_in & req_ready_out).

Optional Feature:
- Macro: INSTR_MISALIGN_CHECK_EN.
- Defined:
  - Adds output resp_err_out (1 bit, reset 0).
  - A request with req_addr_in[1:0] != 0 is still accepted and travels the pipeline.
  - Its response has resp_err_out=1 and resp_instr_out=0.
  - Aligned responses have resp_err_out=0.
  - resp_err_out follows the same hold and flush rules as resp_valid_out.
- Not defined:
  - The port is absent.
  - req_addr_in[1:0] is ignored, and misaligned addresses return the word containing them.

Test Plan:
- Streaming fetch:
  - Stimulus: preload words 0..3 = 32'hE3A00001..32'hE3A00004, LATENCY=2, request 0x0, 0x4, 0x8, 0xC on consecutive cycles.
  - Required response: resp_valid_out high for 4 consecutive cycles starting 2 cycles after the first accept, in order with matching addresses.
- Hold:
  - Stimulus: during a stream, assert hold_in for 3 cycles while the 0x4 response is on the outputs.
  - Required response: resp_addr_out=0x4 and resp_instr_out=32'hE3A00002 are stable for 3 cycles, req_ready_out=0, and the stream resumes with no loss or duplication after release.
- Flush:
  - Stimulus: with 0x8 and 0xC in flight, pulse flush_in with a simultaneous request to 0x40 (word = 32'hEAFFFFFE).
  - Required response: 0x8 and 0xC are never returned, and 0x40 is returned valid 2 cycles later.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously between clock edges with 2 requests in flight.
  - Required response: resp_valid_out and busy_out drop to 0 immediately; after release, request 0x0 returns the preloaded data, showing the memory survived reset.
- Boundary:
  - Stimulus: request 0x3FC (last word), then 0x400 (out of range); write and read word 5 in the same cycle.
  - Required response: 0x3FC returns its stored data, 0x400 returns 0, and the word-5 read returns old data with new data on the next read.
- Misalign (INSTR_MISALIGN_CHECK_EN defined):
  - Stimulus: request 0x6.
  - Required response: resp_err_out=1 and resp_instr_out=0, while an aligned request on the next cycle returns resp_err_out=0.
